// File: rtl/cache_set_nway_if.sv
// Controller-side bundle for one cache set: lookup req/resp, victim/writeback view, refill beats, flash invalidate.
interface cache_set_nway_if #(
   parameter int WAYS             = 2,
   parameter int CACHE_LINE_WIDTH = 6,
   parameter int TAG_WIDTH        = 20
);
   localparam int OFFSET_WIDTH = CACHE_LINE_WIDTH - 2;
   localparam int WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic                    req_valid;
   logic                    req_we;
   logic [TAG_WIDTH-1:0]    req_tag;
   logic [OFFSET_WIDTH-1:0] req_off;
   logic [31:0]             req_wdata;
   logic [3:0]              req_byte_enable;
   logic                    resp_valid;
   logic                    resp_hit;
   logic [31:0]             resp_rdata;
   logic [WAY_W-1:0]        victim_way;
   logic                    victim_valid;
   logic                    victim_dirty;
   logic [TAG_WIDTH-1:0]    victim_tag;
   logic [OFFSET_WIDTH-1:0] wb_off;
   logic [31:0]             wb_rdata;
   logic                    fill_start;
   logic [TAG_WIDTH-1:0]    fill_tag;
   logic                    fill_data_valid;
   logic [31:0]             fill_data;
   logic                    fill_last;
   logic                    fill_busy;
   logic                    fill_done;
   logic                    fill_err;
   logic                    inv_all;

   modport master (
      output req_valid, req_we, req_tag, req_off, req_wdata, req_byte_enable,
      output wb_off, fill_start, fill_tag, fill_data_valid, fill_data, fill_last, inv_all,
      input  resp_valid, resp_hit, resp_rdata, victim_way, victim_valid, victim_dirty,
      input  victim_tag, wb_rdata, fill_busy, fill_done, fill_err
   );

   modport slave (
      input  req_valid, req_we, req_tag, req_off, req_wdata, req_byte_enable,
      input  wb_off, fill_start, fill_tag, fill_data_valid, fill_data, fill_last, inv_all,
      output resp_valid, resp_hit, resp_rdata, victim_way, victim_valid, victim_dirty,
      output victim_tag, wb_rdata, fill_busy, fill_done, fill_err
   );
endinterface

// File: rtl/cache_set_nway.sv
// One N-way cache set with true-LRU replacement, sequential line fill, victim writeback port and flash invalidate.
// Response one cycle after an accepted request; requests are refused while a fill runs or inv_all is high.
module cache_set_nway #(
   parameter int WAYS             = 2,
   parameter int CACHE_LINE_WIDTH = 6,
   parameter int TAG_WIDTH        = 20
) (
   input logic             clk,
   input logic             rst,
   cache_set_nway_if.slave bus
);
   localparam int OFFSET_WIDTH = CACHE_LINE_WIDTH - 2;
   localparam int WORDS        = 1 << OFFSET_WIDTH;
   localparam int WAY_W        = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(WORDS - 1);
   localparam logic [WAY_W-1:0]        OLDEST    = WAY_W'(WAYS - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t                  state;
   logic [WAYS-1:0]         valid;
   logic [WAYS-1:0]         dirty;
   logic [TAG_WIDTH-1:0]    tag  [WAYS];
   logic [31:0]             data [WAYS][WORDS];
   logic [WAY_W-1:0]        age  [WAYS];
   logic [WAY_W-1:0]        fill_way;
   logic [TAG_WIDTH-1:0]    fill_tag_q;
   logic [OFFSET_WIDTH-1:0] fill_cnt;
   logic                    resp_valid_q;
   logic                    resp_hit_q;
   logic [31:0]             resp_rdata_q;
   logic                    fill_busy_q;
   logic                    fill_done_q;
   logic                    fill_err_q;

   logic [WAYS-1:0]         hit_vec;
   logic                    hit_any;
   logic [WAY_W-1:0]        hit_way;
   logic [WAY_W-1:0]        victim;
   logic                    victim_found;
   logic                    fill_ok;
   logic                    touch_en;
   logic [WAY_W-1:0]        touch_way;

   always_comb begin
      hit_vec = '0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid[w] && (tag[w] == bus.req_tag);
         if (hit_vec[w]) hit_way = WAY_W'(w);
      end
   end

   assign hit_any = |hit_vec;

   // Invalid ways are preferred; the descending scan leaves the lowest invalid index.
   always_comb begin
      victim       = '0;
      victim_found = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w]) begin
            victim       = WAY_W'(w);
            victim_found = 1'b1;
         end
      end
      if (!victim_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age[w] == OLDEST) victim = WAY_W'(w);
         end
      end
      if (state == FILL) victim = fill_way;
   end

   assign fill_ok = (state == FILL) && bus.fill_data_valid && bus.fill_last && (fill_cnt == LAST_WORD);

   always_comb begin
      touch_en  = 1'b0;
      touch_way = hit_way;
      if (!bus.inv_all) begin
         if (state == IDLE && bus.req_valid && hit_any) begin
            touch_en = 1'b1;
         end else if (fill_ok) begin
            touch_en  = 1'b1;
            touch_way = fill_way;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         valid        <= '0;
         dirty        <= '0;
         fill_way     <= '0;
         fill_tag_q   <= '0;
         fill_cnt     <= '0;
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_rdata_q <= '0;
         fill_busy_q  <= 1'b0;
         fill_done_q  <= 1'b0;
         fill_err_q   <= 1'b0;
         for (int w = 0; w < WAYS; w++) begin
            tag[w] <= '0;
            age[w] <= WAY_W'(w);
            for (int i = 0; i < WORDS; i++) data[w][i] <= '0;
         end
      end else begin
         resp_valid_q <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_rdata_q <= '0;
         fill_done_q  <= 1'b0;
         fill_err_q   <= 1'b0;

         // Younger ways than the touched one age by one, keeping ages a permutation.
         if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (age[w] < age[touch_way]) age[w] <= age[w] + 1'b1;
            end
            age[touch_way] <= '0;
         end

         if (bus.inv_all) begin
            valid       <= '0;
            dirty       <= '0;
            state       <= IDLE;
            fill_busy_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.req_valid) begin
                     resp_valid_q <= 1'b1;
                     resp_hit_q   <= hit_any;
                     resp_rdata_q <= hit_any ? data[hit_way][bus.req_off] : '0;
                     if (hit_any && bus.req_we) begin
                        dirty[hit_way] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                           if (bus.req_byte_enable[b])
                              data[hit_way][bus.req_off][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                        end
                     end
                  end
                  if (bus.fill_start) begin
                     state         <= FILL;
                     fill_busy_q   <= 1'b1;
                     fill_way      <= victim;
                     fill_tag_q    <= bus.fill_tag;
                     fill_cnt      <= '0;
                     valid[victim] <= 1'b0;
                  end
               end
               FILL: begin
                  if (bus.fill_data_valid) begin
                     data[fill_way][fill_cnt] <= bus.fill_data;
                     fill_cnt                 <= fill_cnt + 1'b1;
                     if (bus.fill_last) begin
                        state       <= IDLE;
                        fill_busy_q <= 1'b0;
                        if (fill_cnt == LAST_WORD) begin
                           tag[fill_way]   <= fill_tag_q;
                           valid[fill_way] <= 1'b1;
                           dirty[fill_way] <= 1'b0;
                           fill_done_q     <= 1'b1;
                        end else begin
                           fill_err_q <= 1'b1;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_hit     = resp_hit_q;
   assign bus.resp_rdata   = resp_rdata_q;
   assign bus.fill_busy    = fill_busy_q;
   assign bus.fill_done    = fill_done_q;
   assign bus.fill_err     = fill_err_q;
   assign bus.victim_way   = victim;
   assign bus.victim_valid = valid[victim];
   assign bus.victim_dirty = dirty[victim];
   assign bus.victim_tag   = tag[victim];
   assign bus.wb_rdata     = data[victim][bus.wb_off];
endmodule

// File: tb/tb_cache_set_nway.sv
// Directed bench for cache_set_nway: a line/LRU-list model checked every cycle, plus literal expectations.
module tb_cache_set_nway;
   localparam int WAYS  = 2;
   localparam int CLW   = 6;
   localparam int TW    = 20;
   localparam int OW    = CLW - 2;
   localparam int WORDS = 1 << OW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cache_set_nway_if #(.WAYS(WAYS), .CACHE_LINE_WIDTH(CLW), .TAG_WIDTH(TW)) bus();

   cache_set_nway #(.WAYS(WAYS), .CACHE_LINE_WIDTH(CLW), .TAG_WIDTH(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   bit          m_valid [WAYS];
   bit          m_dirty [WAYS];
   logic [TW-1:0] m_tag [WAYS];
   logic [31:0] m_data  [WAYS][WORDS];
   int          lru_q[$];
   bit          m_busy   = 1'b0;
   int          m_fway   = 0;
   logic [TW-1:0] m_ftag = '0;
   int          m_cnt    = 0;
   bit          model_ok = 1'b0;
   bit          e_rv, e_hit, e_done, e_err;
   logic [31:0] e_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_victim();
      if (m_busy) return m_fway;
      for (int w = 0; w < WAYS; w++) if (!m_valid[w]) return w;
      return lru_q[lru_q.size() - 1];
   endfunction

   task automatic touch(input int h);
      for (int i = 0; i < lru_q.size(); i++) begin
         if (lru_q[i] == h) begin
            lru_q.delete(i);
            break;
         end
      end
      lru_q.push_front(h);
   endtask

   // Model: lru_q lists ways from most to least recently used.
   always @(posedge clk) begin
      int v, h;
      logic [31:0] mask;
      e_rv = 0; e_hit = 0; e_done = 0; e_err = 0; e_rdata = '0;
      if (rst) begin
         for (int w = 0; w < WAYS; w++) begin
            m_valid[w] = 0; m_dirty[w] = 0; m_tag[w] = '0;
            for (int i = 0; i < WORDS; i++) m_data[w][i] = '0;
         end
         lru_q.delete();
         for (int w = 0; w < WAYS; w++) lru_q.push_back(w);
         m_busy = 0; m_cnt = 0; model_ok = 1;
      end else if (bus.inv_all) begin
         for (int w = 0; w < WAYS; w++) begin m_valid[w] = 0; m_dirty[w] = 0; end
         m_busy = 0;
      end else if (!m_busy) begin
         v = model_victim();
         if (bus.req_valid) begin
            h = -1;
            for (int w = 0; w < WAYS; w++) if (m_valid[w] && m_tag[w] == bus.req_tag) h = w;
            e_rv = 1;
            if (h >= 0) begin
               e_hit   = 1;
               e_rdata = m_data[h][bus.req_off];
               if (bus.req_we) begin
                  mask = {{8{bus.req_byte_enable[3]}}, {8{bus.req_byte_enable[2]}},
                          {8{bus.req_byte_enable[1]}}, {8{bus.req_byte_enable[0]}}};
                  m_data[h][bus.req_off] = (m_data[h][bus.req_off] & ~mask) | (bus.req_wdata & mask);
                  m_dirty[h] = 1;
               end
               touch(h);
            end
         end
         if (bus.fill_start) begin
            m_busy = 1; m_fway = v; m_ftag = bus.fill_tag; m_cnt = 0; m_valid[v] = 0;
         end
      end else if (bus.fill_data_valid) begin
         m_data[m_fway][m_cnt] = bus.fill_data;
         if (bus.fill_last) begin
            if (m_cnt == WORDS - 1) begin
               m_tag[m_fway] = m_ftag; m_valid[m_fway] = 1; m_dirty[m_fway] = 0;
               touch(m_fway);
               e_done = 1;
            end else begin
               e_err = 1;
            end
            m_busy = 0;
         end
         m_cnt = (m_cnt + 1) % WORDS;
      end
   end

   always @(negedge clk) begin
      int v;
      if (model_ok) begin
         v = model_victim();
         chk("resp_valid",   32'(bus.resp_valid),   32'(e_rv));
         chk("resp_hit",     32'(bus.resp_hit),     32'(e_hit));
         chk("resp_rdata",   bus.resp_rdata,        e_rdata);
         chk("fill_busy",    32'(bus.fill_busy),    32'(m_busy));
         chk("fill_done",    32'(bus.fill_done),    32'(e_done));
         chk("fill_err",     32'(bus.fill_err),     32'(e_err));
         chk("victim_way",   32'(bus.victim_way),   32'(v));
         chk("victim_valid", 32'(bus.victim_valid), 32'(m_valid[v]));
         chk("victim_dirty", 32'(bus.victim_dirty), 32'(m_dirty[v]));
         chk("victim_tag",   32'(bus.victim_tag),   32'(m_tag[v]));
         chk("wb_rdata",     bus.wb_rdata,          m_data[v][bus.wb_off]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input bit we, input logic [TW-1:0] t, input int off,
                      input logic [31:0] wd, input logic [3:0] be);
      bus.req_valid = 1; bus.req_we = we; bus.req_tag = t; bus.req_off = OW'(off);
      bus.req_wdata = wd; bus.req_byte_enable = be;
      tick();
      bus.req_valid = 0; bus.req_we = 0;
   endtask

   task automatic fill(input logic [TW-1:0] t, input logic [31:0] base, input int beats);
      bus.fill_start = 1; bus.fill_tag = t;
      tick();
      bus.fill_start = 0;
      for (int i = 0; i < beats; i++) begin
         if (i == 8) begin
            bus.fill_data_valid = 0;
            tick();
         end
         bus.fill_data_valid = 1; bus.fill_data = base + 32'(i); bus.fill_last = (i == beats - 1);
         tick();
      end
      bus.fill_data_valid = 0; bus.fill_last = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 0; bus.req_we = 0; bus.req_tag = '0; bus.req_off = '0;
      bus.req_wdata = '0; bus.req_byte_enable = '0; bus.wb_off = '0;
      bus.fill_start = 0; bus.fill_tag = '0; bus.fill_data_valid = 0;
      bus.fill_data = '0; bus.fill_last = 0; bus.inv_all = 0;
      tick(); tick();
      rst = 0;
      chk("rst_resp_valid",   32'(bus.resp_valid),   0);
      chk("rst_fill_busy",    32'(bus.fill_busy),    0);
      chk("rst_victim_way",   32'(bus.victim_way),   0);
      chk("rst_victim_valid", 32'(bus.victim_valid), 0);

      req(0, 20'h12345, 3, '0, '0);
      chk("miss_resp_valid", 32'(bus.resp_valid), 1);
      chk("miss_hit",        32'(bus.resp_hit),   0);
      chk("miss_rdata",      bus.resp_rdata,      0);

      fill(20'h12345, 32'hA000_0000, 16);
      chk("fill0_done", 32'(bus.fill_done), 1);
      chk("fill0_busy", 32'(bus.fill_busy), 0);
      tick();
      chk("fill0_done_pulse", 32'(bus.fill_done), 0);
      req(0, 20'h12345, 3, '0, '0);
      chk("hit_after_fill", 32'(bus.resp_hit), 1);
      chk("rdata_after_fill", bus.resp_rdata, 32'hA000_0003);
      chk("victim_inv_way1", 32'(bus.victim_way), 1);
      chk("victim_inv_valid", 32'(bus.victim_valid), 0);

      req(1, 20'h12345, 3, 32'hDEAD_BEEF, 4'b0011);
      chk("store_hit", 32'(bus.resp_hit), 1);
      chk("store_old_data", bus.resp_rdata, 32'hA000_0003);
      req(0, 20'h12345, 3, '0, '0);
      chk("reload_merged", bus.resp_rdata, 32'hA000_BEEF);

      fill(20'h00ABC, 32'hB000_0000, 16);
      chk("fill1_done", 32'(bus.fill_done), 1);
      chk("lru_victim0", 32'(bus.victim_way), 0);
      chk("victim0_dirty", 32'(bus.victim_dirty), 1);
      chk("victim0_tag", 32'(bus.victim_tag), 32'h12345);
      bus.wb_off = OW'(3);
      #1;
      chk("wb_dirty_word", bus.wb_rdata, 32'hA000_BEEF);

      req(0, 20'h12345, 0, '0, '0);
      chk("hit_way0_rdata", bus.resp_rdata, 32'hA000_0000);
      chk("victim_after_way0", 32'(bus.victim_way), 1);
      bus.wb_off = OW'(5);
      #1;
      chk("wb_way1_w5", bus.wb_rdata, 32'hB000_0005);
      req(0, 20'h00ABC, 1, '0, '0);
      chk("hit_way1_rdata", bus.resp_rdata, 32'hB000_0001);
      chk("victim_after_way1", 32'(bus.victim_way), 0);
      chk("wb_way0_w5", bus.wb_rdata, 32'hA000_0005);

      fill(20'h55555, 32'hC000_0000, 7);
      chk("short_err", 32'(bus.fill_err), 1);
      chk("short_no_done", 32'(bus.fill_done), 0);
      tick();
      chk("short_err_pulse", 32'(bus.fill_err), 0);
      req(0, 20'h12345, 0, '0, '0);
      chk("short_old_tag_miss", 32'(bus.resp_hit), 0);
      req(0, 20'h55555, 0, '0, '0);
      chk("short_new_tag_miss", 32'(bus.resp_hit), 0);
      chk("short_victim_way", 32'(bus.victim_way), 0);
      chk("short_victim_valid", 32'(bus.victim_valid), 0);
      req(0, 20'h00ABC, 2, '0, '0);
      chk("other_way_still_hits", 32'(bus.resp_hit), 1);

      bus.fill_start = 1; bus.fill_tag = 20'h77777;
      tick();
      bus.fill_start = 0;
      for (int i = 0; i < 4; i++) begin
         bus.fill_data_valid = 1; bus.fill_data = 32'hD000_0000 + 32'(i);
         bus.req_valid = (i == 1); bus.req_tag = 20'h00ABC; bus.fill_start = (i == 1);
         tick();
         if (i == 1) chk("req_during_fill", 32'(bus.resp_valid), 0);
         bus.req_valid = 0; bus.fill_start = 0;
      end
      bus.inv_all = 1; bus.fill_data = 32'hD000_0004; bus.req_valid = 1;
      tick();
      bus.inv_all = 0; bus.fill_data_valid = 0; bus.req_valid = 0;
      chk("inv_busy", 32'(bus.fill_busy), 0);
      chk("inv_no_done", 32'(bus.fill_done), 0);
      chk("inv_no_err", 32'(bus.fill_err), 0);
      chk("inv_req_refused", 32'(bus.resp_valid), 0);
      tick();
      chk("inv_no_done_later", 32'(bus.fill_done), 0);
      req(0, 20'h00ABC, 2, '0, '0);
      chk("inv_miss_way1", 32'(bus.resp_hit), 0);
      req(0, 20'h77777, 0, '0, '0);
      chk("inv_miss_fill_tag", 32'(bus.resp_hit), 0);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
